// File: rtl/mtr_drv_pkg.sv
// Shared types, constants and helpers for the dual H-bridge motor driver.
// Holds duty/speed typedefs, saturation limits and speed-to-duty mapping.
package mtr_drv_pkg;

    typedef logic [10:0]        duty_t;
    typedef logic signed [11:0] spd_t;

    localparam spd_t  SPD_MAX  = 12'sd1023;
    localparam spd_t  SPD_MIN  = -12'sd1023;
    localparam duty_t DUTY_MID = 11'h400;
    localparam duty_t CNT_MAX  = 11'h7FF;

    // Symmetric clip keeps -2048 and -1024 from reaching the duty adder.
    function automatic spd_t sat_spd(input spd_t spd);
        if (spd > SPD_MAX)
            return SPD_MAX;
        else if (spd < SPD_MIN)
            return SPD_MIN;
        return spd;
    endfunction

    // Mirrored motor subtracts so forward speed means the same
    // direction of travel on both sides. Clipped input keeps the
    // 12-bit result inside 0x001..0x7FF, so dropping bit 11 is safe.
    function automatic duty_t spd_to_duty(input spd_t spd,
                                          input logic mirror);
        logic [11:0] mag;
        logic [11:0] sum;
        mag = sat_spd(spd);
        if (mirror)
            sum = {1'b0, DUTY_MID} - mag;
        else
            sum = {1'b0, DUTY_MID} + mag;
        return sum[10:0];
    endfunction

endpackage

// File: rtl/mtr_drv_pwm11.sv
// Per-motor complementary PWM cell with dead-time between phases.
// Ports: clk, rst, cnt (shared counter), duty -> pwm1, pwm2 (registered).
module pwm11
    import mtr_drv_pkg::*;
#(
    parameter duty_t NONOVERLAP = 11'h020
) (
    input  logic  clk,
    input  logic  rst,
    input  duty_t cnt,
    input  duty_t duty,
    output logic  pwm1,
    output logic  pwm2
);

    // 12-bit so a late turn-on point past 0x7FF never matches.
    logic [11:0] on_pt;

    assign on_pt = {1'b0, duty} + {1'b0, NONOVERLAP};

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm1 <= 1'b0;
            pwm2 <= 1'b0;
        end else begin
            if (cnt >= duty)
                pwm2 <= 1'b0;
            else if (cnt == NONOVERLAP)
                pwm2 <= 1'b1;

            if (cnt == CNT_MAX)
                pwm1 <= 1'b0;
            else if ({1'b0, cnt} == on_pt)
                pwm1 <= 1'b1;
        end
    end

endmodule

// File: rtl/mtr_drv.sv
// Dual H-bridge driver: maps signed speeds to duties and drives PWM pairs.
// Ports: clk, rst, lft_spd, rght_spd -> lft_pwm1/2, rght_pwm1/2, pwm_sync.
// Build option MTR_DRV_DUTY_SYNC_EN: duty changes apply at period start only.
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter duty_t NONOVERLAP = 11'h020
) (
    input  logic clk,
    input  logic rst,
    input  spd_t lft_spd,
    input  spd_t rght_spd,
    output logic lft_pwm1,
    output logic lft_pwm2,
    output logic rght_pwm1,
    output logic rght_pwm2,
    output logic pwm_sync
);

    duty_t cnt;
    duty_t lft_duty;
    duty_t rght_duty;
    duty_t lft_next;
    duty_t rght_next;

    assign lft_next  = spd_to_duty(lft_spd, 1'b0);
    assign rght_next = spd_to_duty(rght_spd, 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            pwm_sync <= 1'b0;
        end else begin
            cnt      <= cnt + 11'd1;
            pwm_sync <= (cnt == CNT_MAX);
        end
    end

`ifdef MTR_DRV_DUTY_SYNC_EN
    duty_t lft_shadow;
    duty_t rght_shadow;

    // Active duty only moves on the wrap, so a period never mixes duties.
    always_ff @(posedge clk) begin
        if (rst) begin
            lft_shadow  <= DUTY_MID;
            rght_shadow <= DUTY_MID;
            lft_duty    <= DUTY_MID;
            rght_duty   <= DUTY_MID;
        end else begin
            lft_shadow  <= lft_next;
            rght_shadow <= rght_next;
            if (cnt == CNT_MAX) begin
                lft_duty  <= lft_shadow;
                rght_duty <= rght_shadow;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            lft_duty  <= DUTY_MID;
            rght_duty <= DUTY_MID;
        end else begin
            lft_duty  <= lft_next;
            rght_duty <= rght_next;
        end
    end
`endif

    pwm11 #(.NONOVERLAP(NONOVERLAP)) u_lft (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .duty (lft_duty),
        .pwm1 (lft_pwm1),
        .pwm2 (lft_pwm2)
    );

    pwm11 #(.NONOVERLAP(NONOVERLAP)) u_rght (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .duty (rght_duty),
        .pwm1 (rght_pwm1),
        .pwm2 (rght_pwm2)
    );

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: reset, duty mapping, PWM high times,
// period sync, mid-period changes, random stimulus, mid-period reset.
module tb_mtr_drv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lft_spd = 12'h000;
    logic [11:0] rght_spd = 12'h000;
    logic        lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, pwm_sync;

    int checks = 0;
    int errors = 0;

    mtr_drv dut (
        .clk       (clk),
        .rst       (rst),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .lft_pwm1  (lft_pwm1),
        .lft_pwm2  (lft_pwm2),
        .rght_pwm1 (rght_pwm1),
        .rght_pwm2 (rght_pwm2),
        .pwm_sync  (pwm_sync)
    );

    always #5 clk = ~clk;

    // Phases of one bridge must never be on together.
    always @(negedge clk) begin
        checks++;
        if ((lft_pwm1 === 1'b1 && lft_pwm2 === 1'b1) ||
            (rght_pwm1 === 1'b1 && rght_pwm2 === 1'b1)) begin
            errors++;
            $display("FAIL overlap t=%0t lft=%b%b rght=%b%b want no pair high",
                     $time, lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2);
        end
    end

    // Waits for pwm_sync, then counts high clocks over one 2048-clock
    // period; ok means sync was found and recurs exactly 2048 later.
    task automatic measure(input int chg, input logic [11:0] nl,
                           output int l2, output int l1,
                           output int r2, output int r1,
                           output int syncs, output bit ok);
        l2 = 0; l1 = 0; r2 = 0; r1 = 0; syncs = 0; ok = 1'b0;
        for (int i = 0; i < 4200 && pwm_sync !== 1'b1; i++)
            @(negedge clk);
        if (pwm_sync !== 1'b1)
            return;
        for (int i = 0; i < 2048; i++) begin
            if (i == chg)
                lft_spd = nl;
            l2    += int'(lft_pwm2 === 1'b1);
            l1    += int'(lft_pwm1 === 1'b1);
            r2    += int'(rght_pwm2 === 1'b1);
            r1    += int'(rght_pwm1 === 1'b1);
            syncs += int'(pwm_sync === 1'b1);
            @(negedge clk);
        end
        ok = (pwm_sync === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lft_spd = 12'h123;
        rght_spd = 12'h000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, pwm_sync} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outs cycle %0d got %b want 00000", i,
                         {lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, pwm_sync});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        int g[6];
        int e[6];
        bit ok;
        lft_spd = 12'h000;
        rght_spd = 12'h000;
        @(negedge clk);
        measure(-1, 12'h0, g[0], g[1], g[2], g[3], g[4], ok);
        g[5] = int'(ok);
        e = '{992, 991, 992, 991, 1, 1};
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (g[k] !== e[k]) begin
                errors++;
                $display("FAIL zero item%0d (l2,l1,r2,r1,syncs,period) got %0d want %0d",
                         k, g[k], e[k]);
            end
        end
    endtask

    task automatic test_duty();
        logic [11:0] ls[4];
        logic [11:0] rs[4];
        int ex[4][4];
        int g[5];
        bit ok;
        ls = '{12'h3A4, 12'h500, 12'h800, 12'hC00};
        rs = '{12'h05C, 12'h500, 12'h800, 12'h3FF};
        ex = '{'{1924, 59, 900, 1083},
               '{2015, 0, 0, 2014},
               '{0, 2014, 2015, 0},
               '{0, 2014, 0, 2014}};
        for (int v = 0; v < 4; v++) begin
            lft_spd = ls[v];
            rght_spd = rs[v];
            @(negedge clk);
            measure(-1, 12'h0, g[0], g[1], g[2], g[3], g[4], ok);
            checks++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL duty%0d period got ok=%0d want 1", v, ok);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (g[k] !== ex[v][k]) begin
                    errors++;
                    $display("FAIL duty%0d spd=%h/%h item%0d (l2,l1,r2,r1) got %0d want %0d",
                             v, ls[v], rs[v], k, g[k], ex[v][k]);
                end
            end
        end
    endtask

    task automatic test_mid_change();
        int g[5];
        int e0[4];
        int e1[4];
        bit ok;
`ifdef MTR_DRV_DUTY_SYNC_EN
        e0 = '{992, 991, 992, 991};
`else
        e0 = '{1248, 735, 992, 991};
`endif
        e1 = '{1248, 735, 992, 991};
        lft_spd = 12'h000;
        rght_spd = 12'h000;
        @(negedge clk);
        measure(12'h100, 12'h100, g[0], g[1], g[2], g[3], g[4], ok);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (g[k] !== e0[k]) begin
                errors++;
                $display("FAIL mid_cur item%0d got %0d want %0d", k, g[k], e0[k]);
            end
        end
        measure(-1, 12'h0, g[0], g[1], g[2], g[3], g[4], ok);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (g[k] !== e1[k]) begin
                errors++;
                $display("FAIL mid_next item%0d got %0d want %0d", k, g[k], e1[k]);
            end
        end
    endtask

    task automatic test_random();
        int syncs = 0;
        for (int p = 0; p < 20 * 2048; p++) begin
            lft_spd = 12'($urandom);
            rght_spd = 12'($urandom);
            syncs += int'(pwm_sync === 1'b1);
            @(negedge clk);
        end
        checks++;
        if (syncs !== 20) begin
            errors++;
            $display("FAIL random_syncs got %0d want 20", syncs);
        end
    endtask

    task automatic test_reset_mid();
        int g[5];
        int e[4];
        int k;
        bit ok;
        e = '{1924, 59, 900, 1083};
        lft_spd = 12'h3A4;
        rght_spd = 12'h05C;
        @(negedge clk);
        measure(-1, 12'h0, g[0], g[1], g[2], g[3], g[4], ok);
        repeat (12'h300) @(negedge clk);
        checks++;
        if (lft_pwm2 !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst lft_pwm2 got %b want 1", lft_pwm2);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, pwm_sync} !== 5'b0) begin
            errors++;
            $display("FAIL mid_rst_outs got %b want 00000",
                     {lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, pwm_sync});
        end
        k = 0;
        while (pwm_sync !== 1'b1 && k < 4200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== 2048) begin
            errors++;
            $display("FAIL rst_to_sync got %0d clocks want 2048", k);
        end
        measure(-1, 12'h0, g[0], g[1], g[2], g[3], g[4], ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL resume_period got ok=%0d want 1", ok);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (g[j] !== e[j]) begin
                errors++;
                $display("FAIL resume item%0d got %0d want %0d", j, g[j], e[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_duty();
        test_mid_change();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
